// File: rtl/muldiv_unit_pkg.sv
// Shared definitions for the multiply/divide unit.
//   - one-hot mul_control encodings from the ALU control decoder
//   - FSM state encoding
//   - latched-operation descriptor
//   - helper that recognises a legal (exactly one-hot) op select
package muldiv_unit_pkg;

  localparam logic [3:0] mult_mc  = 4'b0001;
  localparam logic [3:0] multu_mc = 4'b0010;
  localparam logic [3:0] div_mc   = 4'b0100;
  localparam logic [3:0] divu_mc  = 4'b1000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2
  } state_t;

  // What FIX needs to know about the op accepted earlier.
  typedef struct packed {
    logic is_div;
    logic neg_a;   // signed op with negative rs
    logic neg_b;   // signed op with negative rt
  } op_t;

  function automatic logic is_op(input logic [3:0] mc);
    return (mc == mult_mc) || (mc == multu_mc) ||
           (mc == div_mc)  || (mc == divu_mc);
  endfunction

endpackage

// File: rtl/muldiv_core.sv
// Radix-2 iteration datapath shared by multiply and divide.
// Ports:
//   clk, rst   clock, synchronous active-high reset
//   start      load operands and set the step counter to XLEN-1
//   step       perform one iteration
//   is_div     operation type sampled on start
//   a, b       unsigned magnitudes (multiplicand/dividend, multiplier/divisor)
//   acc        2*XLEN accumulator: product, or {remainder, quotient}
//   last       the step counter is at 0 (current step is the final one)
module muldiv_core #(
  parameter int XLEN = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              step,
  input  logic              is_div,
  input  logic [XLEN-1:0]   a,
  input  logic [XLEN-1:0]   b,
  output logic [2*XLEN-1:0] acc,
  output logic              last
);

  localparam int CW = (XLEN > 1) ? $clog2(XLEN) : 1;

  logic [XLEN-1:0]   opnd;    // multiplicand or divisor
  logic              div_mode;
  logic [CW-1:0]     cnt;
  logic [2*XLEN-1:0] acc_nx;
  logic [XLEN:0]     sum;
  logic [XLEN:0]     shifted;
  logic [XLEN:0]     diff;

  assign last = (cnt == '0);

  // Multiply keeps {partial_hi, multiplier} in acc and shifts right; divide
  // keeps {remainder, dividend/quotient} and shifts left, so one register
  // serves both.
  always_comb begin
    sum     = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, opnd} : '0);
    shifted = acc[2*XLEN-1:XLEN-1];
    diff    = shifted - {1'b0, opnd};
    acc_nx  = acc;
    if (div_mode) begin
      if (!diff[XLEN]) acc_nx = {diff[XLEN-1:0],    acc[XLEN-2:0], 1'b1};
      else             acc_nx = {shifted[XLEN-1:0], acc[XLEN-2:0], 1'b0};
    end else begin
      acc_nx = {sum, acc[XLEN-1:1]};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc      <= '0;
      opnd     <= '0;
      div_mode <= 1'b0;
      cnt      <= '0;
    end else if (start) begin
      acc      <= is_div ? {{XLEN{1'b0}}, a} : {{XLEN{1'b0}}, b};
      opnd     <= is_div ? b : a;
      div_mode <= is_div;
      cnt      <= CW'(XLEN - 1);
    end else if (step) begin
      acc <= acc_nx;
      if (!last) cnt <= cnt - 1'b1;
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// EX-stage iterative multiply/divide unit owning the HI/LO registers.
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   mul_control       one-hot op select {divu, div, multu, mult}
//   op_valid          EX holds a valid instruction carrying mul_control
//   src_a, src_b      rs / rt operands
//   op_ready          !busy
//   hi_we, lo_we      mthi / mtlo strobes, wdata is the value
//   cancel            squash the in-flight op (blocks accept in IDLE)
//   busy              op in progress (RUN or FIX)
//   done              one-cycle pulse after HI/LO took an op result
//   hi, lo            architectural HI / LO
// Timing: accept at T, RUN T+1..T+XLEN, FIX T+XLEN+1, result and done
// visible at T+XLEN+2.
module muldiv_unit
  import muldiv_unit_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [3:0]      mul_control,
  input  logic            op_valid,
  input  logic [XLEN-1:0] src_a,
  input  logic [XLEN-1:0] src_b,
  output logic            op_ready,
  input  logic            hi_we,
  input  logic            lo_we,
  input  logic [XLEN-1:0] wdata,
  input  logic            cancel,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] hi,
  output logic [XLEN-1:0] lo
);

  state_t            state, state_nx;
  op_t               op;
  logic [XLEN-1:0]   a_raw;    // kept for the divide-by-zero HI result
  logic              b_zero;
  logic              accept, step, write_res, last;
  logic              signed_op, a_neg, b_neg, is_div;
  logic [XLEN-1:0]   a_mag, b_mag;
  logic [2*XLEN-1:0] acc, prod;
  logic [XLEN-1:0]   quo, rem, res_hi, res_lo;

  // ---- accept and operand conditioning ----
  assign accept    = (state == IDLE) && op_valid && is_op(mul_control) && !cancel;
  assign signed_op = mul_control[0] | mul_control[2];
  assign is_div    = mul_control[2] | mul_control[3];
  assign a_neg     = signed_op & src_a[XLEN-1];
  assign b_neg     = signed_op & src_b[XLEN-1];
  assign a_mag     = a_neg ? -src_a : src_a;
  assign b_mag     = b_neg ? -src_b : src_b;

  always_ff @(posedge clk) begin
    if (rst) begin
      op     <= '0;
      a_raw  <= '0;
      b_zero <= 1'b0;
    end else if (accept) begin
      op     <= '{is_div: is_div, neg_a: a_neg, neg_b: b_neg};
      a_raw  <= src_a;
      b_zero <= (src_b == '0);
    end
  end

  muldiv_core #(.XLEN(XLEN)) u_core (
    .clk    (clk),
    .rst    (rst),
    .start  (accept),
    .step   (step),
    .is_div (is_div),
    .a      (a_mag),
    .b      (b_mag),
    .acc    (acc),
    .last   (last)
  );

  // ---- FSM: state register ----
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // ---- FSM: next state ----
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (accept) state_nx = RUN;
      RUN:     if (cancel) state_nx = IDLE;
               else if (last) state_nx = FIX;
      FIX:     state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // ---- FSM: outputs ----
  always_comb begin
    busy      = (state != IDLE);
    op_ready  = !busy;
    step      = (state == RUN);
    write_res = (state == FIX) && !cancel;
  end

  // ---- sign correction ----
  // Remainder follows the dividend's sign; quotient and product are negated
  // when operand signs differ. Divide by zero bypasses correction entirely.
  always_comb begin
    quo    = acc[XLEN-1:0];
    rem    = acc[2*XLEN-1:XLEN];
    prod   = (op.neg_a ^ op.neg_b) ? -acc : acc;
    res_hi = prod[2*XLEN-1:XLEN];
    res_lo = prod[XLEN-1:0];
    if (op.is_div) begin
      if (b_zero) begin
        res_hi = a_raw;
        res_lo = '1;
      end else begin
        res_hi = op.neg_a ? -rem : rem;
        res_lo = (op.neg_a ^ op.neg_b) ? -quo : quo;
      end
    end
  end

  // ---- HI/LO and done ----
  // An op result in FIX wins over a same-cycle mthi/mtlo.
  always_ff @(posedge clk) begin
    if (rst) begin
      hi   <= '0;
      lo   <= '0;
      done <= 1'b0;
    end else begin
      done <= write_res;
      if (write_res) begin
        hi <= res_hi;
        lo <= res_lo;
      end else begin
        if (hi_we) hi <= wdata;
        if (lo_we) lo <= wdata;
      end
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed corner cases plus random ops
// compared against a 64-bit arithmetic reference model.
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  mul_control;
  logic        op_valid;
  logic [31:0] src_a, src_b, wdata;
  logic        op_ready, hi_we, lo_we, cancel, busy, done;
  logic [31:0] hi, lo;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  muldiv_unit #(.XLEN(32)) dut (
    .clk(clk), .rst(rst), .mul_control(mul_control), .op_valid(op_valid),
    .src_a(src_a), .src_b(src_b), .op_ready(op_ready), .hi_we(hi_we),
    .lo_we(lo_we), .wdata(wdata), .cancel(cancel), .busy(busy),
    .done(done), .hi(hi), .lo(lo)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference: plain 64-bit arithmetic on the architectural definition.
  task automatic model(input logic [3:0] mc, input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] eh, output logic [31:0] el);
    longint      sa, sb, q, r;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    eh = '0; el = '0;
    case (mc)
      4'b0001: begin p = 64'(sa * sb);                   eh = p[63:32]; el = p[31:0]; end
      4'b0010: begin p = {32'd0, a} * {32'd0, b};         eh = p[63:32]; el = p[31:0]; end
      4'b0100: if (b == 0) begin eh = a; el = '1; end
               else begin q = sa / sb; r = sa % sb; el = q[31:0]; eh = r[31:0]; end
      4'b1000: if (b == 0) begin eh = a; el = '1; end
               else begin eh = a % b; el = a / b; end
      default: ;
    endcase
  endtask

  // Called at a negedge while idle. Returns at the negedge of the done cycle.
  task automatic do_op(input string tag, input logic [3:0] mc, input logic [31:0] a,
                       input logic [31:0] b, input int mtlo_at, input logic [31:0] mtlo_val);
    logic [31:0] eh, el;
    int nb = 0;
    int dn = 0;
    model(mc, a, b, eh, el);
    mul_control = mc; op_valid = 1'b1; src_a = a; src_b = b;
    @(negedge clk);
    op_valid = 1'b0; mul_control = '0; src_a = $urandom; src_b = $urandom;
    while (busy && nb < 40) begin
      nb++;
      if (done) dn++;
      if (nb == mtlo_at) begin
        lo_we = 1'b1; wdata = mtlo_val;
        @(negedge clk);
        lo_we = 1'b0;
        chk({tag, "_mtlo_run"}, lo, mtlo_val);
      end else begin
        @(negedge clk);
      end
    end
    chk({tag, "_busy_cycles"}, 32'(nb), 32'd33);
    chk({tag, "_done_while_busy"}, 32'(dn), 32'd0);
    chk({tag, "_done"}, {31'd0, done}, 32'd1);
    chk({tag, "_ready"}, {31'd0, op_ready}, 32'd1);
    chk({tag, "_hi"}, hi, eh);
    chk({tag, "_lo"}, lo, el);
  endtask

  initial begin
    logic [31:0] save_lo, rb;
    logic [3:0]  rmc;
    int dn;
    rst = 1'b1; mul_control = '0; op_valid = 1'b0; src_a = '0; src_b = '0;
    wdata = '0; hi_we = 1'b0; lo_we = 1'b0; cancel = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("rst_hi", hi, 32'd0);
    chk("rst_lo", lo, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_ready", {31'd0, op_ready}, 32'd1);

    // directed arithmetic corners
    do_op("multu_ff", 4'b0010, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, 0);
    @(negedge clk);
    chk("multu_done_pulse", {31'd0, done}, 32'd0);
    do_op("mult_m3x5", 4'b0001, 32'hFFFFFFFD, 32'd5, 0, 0);
    do_op("mult_min", 4'b0001, 32'h80000000, 32'h80000000, 0, 0);
    do_op("div_m7_2", 4'b0100, 32'hFFFFFFF9, 32'd2, 0, 0);
    do_op("divu_100_7", 4'b1000, 32'd100, 32'd7, 0, 0);
    do_op("div_min_m1", 4'b0100, 32'h80000000, 32'hFFFFFFFF, 0, 0);
    do_op("divu_by0", 4'b1000, 32'h1234, 32'd0, 0, 0);
    do_op("div_neg_by0", 4'b0100, 32'hFFFFFF00, 32'd0, 0, 0);
    @(negedge clk);

    // illegal select and cancel in IDLE must not start an op
    mul_control = 4'b0011; op_valid = 1'b1; src_a = 32'd9; src_b = 32'd9;
    @(negedge clk);
    op_valid = 1'b0; mul_control = '0;
    chk("bad_mc_busy", {31'd0, busy}, 32'd0);
    mul_control = 4'b0001; op_valid = 1'b1; cancel = 1'b1;
    @(negedge clk);
    op_valid = 1'b0; mul_control = '0; cancel = 1'b0;
    chk("idle_cancel_busy", {31'd0, busy}, 32'd0);

    // cancel mid-op keeps pre-op HI/LO, no done
    hi_we = 1'b1; wdata = 32'hAAAA0000;
    @(negedge clk);
    hi_we = 1'b0;
    chk("mthi_idle", hi, 32'hAAAA0000);
    save_lo = lo;
    mul_control = 4'b0001; op_valid = 1'b1; src_a = 32'd1234; src_b = 32'd5678;
    @(negedge clk);
    op_valid = 1'b0; mul_control = '0;
    repeat (9) @(negedge clk);
    cancel = 1'b1;
    @(negedge clk);
    cancel = 1'b0;
    chk("cancel_busy", {31'd0, busy}, 32'd0);
    dn = 0;
    repeat (40) begin
      if (done) dn++;
      @(negedge clk);
    end
    chk("cancel_no_done", 32'(dn), 32'd0);
    chk("cancel_hi", hi, 32'hAAAA0000);
    chk("cancel_lo", lo, save_lo);

    // reset mid-op clears HI/LO
    mul_control = 4'b0001; op_valid = 1'b1; src_a = 32'd3; src_b = 32'd7;
    @(negedge clk);
    op_valid = 1'b0; mul_control = '0;
    repeat (9) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rstmid_hi", hi, 32'd0);
    chk("rstmid_lo", lo, 32'd0);
    chk("rstmid_busy", {31'd0, busy}, 32'd0);

    // mtlo during RUN lands, then op result replaces it; back-to-back accept
    do_op("mtlo_run", 4'b1000, 32'd1000, 32'd3, 5, 32'h55);
    do_op("b2b", 4'b0001, 32'hFFFFFFF0, 32'h00012345, 0, 0);
    @(negedge clk);
    chk("b2b_done_pulse", {31'd0, done}, 32'd0);

    // random ops against the model
    for (int i = 0; i < 12; i++) begin
      case ($urandom_range(3))
        0: rmc = 4'b0001;
        1: rmc = 4'b0010;
        2: rmc = 4'b0100;
        default: rmc = 4'b1000;
      endcase
      case ($urandom_range(3))
        0: rb = 32'd0;
        1: rb = 32'($urandom_range(255)) | 32'(($urandom_range(1)) ? 32'hFFFFFF00 : 32'h0);
        default: rb = $urandom;
      endcase
      do_op("rand", rmc, $urandom, rb, 0, 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Iterative multiply/divide unit in the EX stage; consumes the 4-bit mul_control produced by the ALU control decoder for mult, multu, div and divu.
- Owns the architectural HI/LO registers.
- Serves mthi/mtlo writes and supplies HI/LO to the mfhi/mflo writeback path.
- The pipeline stalls on busy.

Parameters:
- XLEN, 32: operand width. HI and LO are XLEN each. The iteration count equals XLEN.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  synchronous reset, active-high.
- mul_control  in  4  one-hot op select (bit0 mult, bit1 multu, bit2 div, bit3 divu); all-zero means no op.
- op_valid  in  1  EX holds a valid instruction carrying mul_control.
- src_a  in  XLEN  rs operand (multiplicand / dividend).
- src_b  in  XLEN  rt operand (multiplier / divisor).
- op_ready  out  1  equals !busy; an op is accepted only when this is high.
- hi_we  in  1  mthi write strobe.
- lo_we  in  1  mtlo write strobe.
- wdata  in  XLEN  mthi/mtlo data (rs value).
- cancel  in  1  flush (exception or branch squash) of the in-flight op.
- busy  out  1  an op is in progress; the pipeline must stall mfhi, mflo and any new mul_control op.
- done  out  1  one-cycle pulse, high the cycle after HI/LO were updated by an op.
- hi  out  XLEN  HI register.
- lo  out  XLEN  LO register.

Behaviour:
- Reset: state IDLE; hi, lo, busy, done and all internal counters and accumulators are 0; op_ready is 1. rst has priority over every other input.
- Accept: an op is accepted when state is IDLE, op_valid is 1, mul_control is exactly one-hot, and cancel is 0.
  - Any other mul_control value is ignored, with no state change.
  - The accept cycle T latches the opcode, the operand signs, |src_a| and |src_b| (signed ops) or the raw operands (unsigned ops), and sets the counter to XLEN-1.
- State machine:
  - IDLE -> RUN on accept.
  - RUN spans cycles T+1..T+XLEN: one radix-2 step per cycle. Multiply is shift-add into a 2*XLEN accumulator. Divide is restoring: shift the remainder left, trial-subtract the divisor, set the quotient bit if the result is non-negative.
  - RUN -> FIX when the counter reaches 0.
  - FIX (cycle T+XLEN+1) applies sign correction and writes HI/LO at its closing edge, then goes to IDLE.
- Timing: for XLEN=32, busy is high T+1..T+33, and done is high and op_ready is 1 in T+34. The total latency from accept to visible HI/LO is XLEN+2 edges.
- Sign rules:
  - mult: the 2*XLEN product is negated if sign(a) != sign(b). HI gets the upper half, LO the lower half.
  - div: LO gets the quotient, negated if the signs differ. HI gets the remainder, which takes the sign of the dividend.
  - The signed corner case -2^31 / -1 gives LO=0x80000000 and HI=0 (two's-complement wrap, no trap).
  - multu and divu apply no sign correction.
- Divide by zero (src_b==0, div or divu): the unit still takes the full latency. Result is LO=all-ones, HI=src_a as latched (raw operand), with no sign correction.
- mthi/mtlo:
  - hi_we or lo_we loads wdata into HI or LO at the edge, in any state.
  - If both are set, both are written.
  - A write during RUN or FIX takes effect immediately, but is overwritten by the op result at FIX.
  - A write in the accept cycle is also overwritten later by the op.
- cancel:
  - In RUN or FIX, cancel forces IDLE at the next edge. HI/LO keep their pre-op values (except for a same-cycle hi_we/lo_we, which still lands), and done is not pulsed.
  - In IDLE, cancel blocks acceptance that cycle.
- Reset mid-operation: the op is abandoned and HI and LO are cleared to 0.
- done deasserts after one cycle unconditionally and never asserts for a cancelled op.

Decomposition:
- Shared define file holds the constants mult_mc=4'b0001, multu_mc=4'b0010, div_mc=4'b0100 and divu_mc=4'b1000, plus the state encodings IDLE, RUN and FIX.
- One natural sub-module, muldiv_core: the iteration datapath (accumulator, remainder, counter), with start, step and result ports. muldiv_unit keeps the FSM, HI/LO, sign handling and mthi/mtlo.

Test Plan:
- multu 0xFFFFFFFF * 0xFFFFFFFF accepted at T -> busy T+1..T+33, HI=0xFFFFFFFE, LO=0x00000001 visible in T+34, done=1 in T+34 only.
- mult -3 (0xFFFFFFFD) * 5 -> HI=0xFFFFFFFF, LO=0xFFFFFFF1. mult 0x80000000 * 0x80000000 -> HI=0x40000000, LO=0.
- div -7/2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF. divu 100/7 -> LO=14, HI=2. div 0x80000000/0xFFFFFFFF -> LO=0x80000000, HI=0.
- divu 0x1234/0 -> after 34 cycles LO=0xFFFFFFFF, HI=0x00001234. mul_control=4'b0011 with op_valid -> no accept, busy stays 0.
- Preload HI=0xAAAA0000 via hi_we in IDLE, start mult, assert cancel at T+10 -> IDLE at T+11, HI=0xAAAA0000, no done pulse. Repeat with rst at T+10 -> HI=LO=0, busy=0.
- lo_we with wdata=0x55 during RUN -> lo=0x55 next cycle, then replaced by the op result at the end of FIX. Back-to-back accept in the done cycle T+34 is accepted.
